// File: rtl/pipe_controlunit.sv
// Pipelined RV32I(+M) control unit: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers, branch resolution in EX and squash/bubble handling.
module pipe_controlunit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned M_EXT          = 0,
    parameter int unsigned ALU_CTRL_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     Instr_i,
    input  logic                      StallD_i,
    input  logic                      BubbleE_i,
    input  logic                      Zero_i,
    input  logic                      Neg_i,
    input  logic                      Carry_i,
    input  logic                      Ovf_i,
    output logic [2:0]                ImmSrc_D_o,
    output logic                      Illegal_D_o,
    output logic [ALU_CTRL_WIDTH-1:0] ALUCtrl_E_o,
    output logic                      ALUSrc_E_o,
    output logic                      Load_E_o,
    output logic                      PCSrc_E_o,
    output logic                      Jalr_E_o,
    output logic                      FlushD_o,
    output logic                      MemWrite_M_o,
    output logic [1:0]                MemType_M_o,
    output logic                      MemSign_M_o,
    output logic                      RegWrite_M_o,
    output logic                      RegWrite_W_o,
    output logic [1:0]                ResultSrc_W_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD    = ALU_CTRL_WIDTH'(0);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB    = ALU_CTRL_WIDTH'(1);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND    = ALU_CTRL_WIDTH'(2);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR     = ALU_CTRL_WIDTH'(3);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR    = ALU_CTRL_WIDTH'(4);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT    = ALU_CTRL_WIDTH'(5);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU   = ALU_CTRL_WIDTH'(6);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL    = ALU_CTRL_WIDTH'(7);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL    = ALU_CTRL_WIDTH'(8);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA    = ALU_CTRL_WIDTH'(9);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_PASSB  = ALU_CTRL_WIDTH'(10);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MUL    = ALU_CTRL_WIDTH'(11);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MULH   = ALU_CTRL_WIDTH'(12);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MULHSU = ALU_CTRL_WIDTH'(13);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MULHU  = ALU_CTRL_WIDTH'(14);

    typedef struct packed {
        logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
        logic                      alu_src;
        logic                      load;
        logic                      branch;
        logic                      jump;
        logic                      jalr;
        logic [2:0]                funct3;
        logic                      mem_write;
        logic [1:0]                mem_type;
        logic                      mem_sign;
        logic                      reg_write;
        logic [1:0]                result_src;
    } ex_ctl_t;

    typedef struct packed {
        logic       mem_write;
        logic [1:0] mem_type;
        logic       mem_sign;
        logic       reg_write;
        logic [1:0] result_src;
    } mem_ctl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wb_ctl_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    ex_ctl_t     dec;
    logic [2:0]  imm_src;
    logic        illegal;
    ex_ctl_t     ex_q;
    mem_ctl_t    mem_q;
    wb_ctl_t     wb_q;
    logic        br_cond;
    logic        pc_src;

    assign instr  = Instr_i[31:0];
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register and upper instruction bits carry no control information.
    logic unused_instr;
    assign unused_instr = ^{instr[24:15], instr[11:7]};
    if (DATA_WIDTH > 32) begin : g_wide
        logic unused_upper;
        assign unused_upper = ^Instr_i[DATA_WIDTH-1:32];
    end

    function automatic logic [ALU_CTRL_WIDTH-1:0] alu_base(input logic [2:0] f3, input logic arith);
        case (f3)
            3'b000:  alu_base = ALU_ADD;
            3'b001:  alu_base = ALU_SLL;
            3'b010:  alu_base = ALU_SLT;
            3'b011:  alu_base = ALU_SLTU;
            3'b100:  alu_base = ALU_XOR;
            3'b101:  alu_base = arith ? ALU_SRA : ALU_SRL;
            3'b110:  alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    endfunction

    // funct3[1:0] gives the access size: 00 byte, 01 half, 10 word.
    function automatic logic [1:0] mem_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   mem_size = 2'b01;
            2'b01:   mem_size = 2'b10;
            default: mem_size = 2'b00;
        endcase
    endfunction

    // ID decode; illegal encodings collapse to an all-zero bubble.
    always_comb begin
        dec     = '0;
        imm_src = 3'b000;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec.alu_ctrl = alu_base(funct3, 1'b0);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.alu_ctrl = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.alu_ctrl = ALU_SRA;
                end else if (funct7 == 7'b0000001 && M_EXT != 0 && !funct3[2]) begin
                    case (funct3[1:0])
                        2'b00:   dec.alu_ctrl = ALU_MUL;
                        2'b01:   dec.alu_ctrl = ALU_MULH;
                        2'b10:   dec.alu_ctrl = ALU_MULHSU;
                        default: dec.alu_ctrl = ALU_MULHU;
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_base(funct3, instr[30]);
            end
            OP_LOAD: begin
                if (funct3 == 3'b011 || funct3[2:1] == 2'b11) begin
                    illegal = 1'b1;
                end else begin
                    dec.load       = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.result_src = 2'b01;
                    dec.mem_type   = mem_size(funct3);
                    dec.mem_sign   = funct3[2];
                end
            end
            OP_STORE: begin
                imm_src = 3'b001;
                if (funct3 > 3'b010) begin
                    illegal = 1'b1;
                end else begin
                    dec.mem_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.mem_type  = mem_size(funct3);
                end
            end
            OP_BRANCH: begin
                imm_src = 3'b010;
                if (funct3[2:1] == 2'b01) begin
                    illegal = 1'b1;
                end else begin
                    dec.branch   = 1'b1;
                    dec.alu_ctrl = ALU_SUB;
                    dec.funct3   = funct3;
                end
            end
            OP_JAL: begin
                imm_src        = 3'b100;
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
            end
            OP_JALR: begin
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b10;
            end
            OP_LUI: begin
                imm_src       = 3'b011;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                imm_src       = 3'b011;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec     = '0;
            imm_src = 3'b000;
        end
    end

    // Branch condition from the ALU flags of A-B.
    always_comb begin
        br_cond = 1'b0;
        case (ex_q.funct3)
            3'b000:  br_cond = Zero_i;
            3'b001:  br_cond = !Zero_i;
            3'b100:  br_cond = Neg_i ^ Ovf_i;
            3'b101:  br_cond = !(Neg_i ^ Ovf_i);
            3'b110:  br_cond = !Carry_i;
            3'b111:  br_cond = Carry_i;
            default: br_cond = 1'b0;
        endcase
    end

    assign pc_src = (ex_q.branch & br_cond) | ex_q.jump;

    // ID/EX: a taken transfer squashes the wrong-path ID instruction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else if (pc_src || BubbleE_i) begin
            ex_q <= '0;
        end else if (!StallD_i) begin
            ex_q <= dec;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= '{mem_write:  ex_q.mem_write,  mem_type:  ex_q.mem_type,
                       mem_sign:   ex_q.mem_sign,   reg_write: ex_q.reg_write,
                       result_src: ex_q.result_src};
            wb_q  <= '{reg_write: mem_q.reg_write, result_src: mem_q.result_src};
        end
    end

    assign ImmSrc_D_o    = imm_src;
    assign Illegal_D_o   = illegal;
    assign ALUCtrl_E_o   = ex_q.alu_ctrl;
    assign ALUSrc_E_o    = ex_q.alu_src;
    assign Load_E_o      = ex_q.load;
    assign PCSrc_E_o     = pc_src;
    assign Jalr_E_o      = ex_q.jalr;
    assign FlushD_o      = pc_src;
    assign MemWrite_M_o  = mem_q.mem_write;
    assign MemType_M_o   = mem_q.mem_type;
    assign MemSign_M_o   = mem_q.mem_sign;
    assign RegWrite_M_o  = mem_q.reg_write;
    assign RegWrite_W_o  = wb_q.reg_write;
    assign ResultSrc_W_o = wb_q.result_src;

endmodule

// File: doc/pipe_controlunit.md
Name: pipe_controlunit

Overview:
Five-stage pipelined successor to the single-cycle control unit. Decodes the RV32I instruction in ID (plus RV32M multiply when enabled). Carries control fields through the ID/EX, EX/MEM and MEM/WB registers. Resolves all six branch conditions plus jal/jalr in EX from the ALU flags, and generates the squash/bubble controls for taken control transfers and load-use stalls.

Parameters:
DATA_WIDTH, 32, instruction width; only bits [31:0] are decoded
M_EXT, 0, 1 = decode mul/mulh/mulhsu/mulhu; 0 = funct7=0000001 R-type is illegal
ALU_CTRL_WIDTH, 4, width of the ALU control field

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
Instr_i  in  DATA_WIDTH  instruction in ID
StallD_i  in  1  hazard-unit stall; freezes ID/EX capture
BubbleE_i  in  1  hazard-unit load-use bubble into EX
Zero_i, Neg_i, Carry_i, Ovf_i  in  1 each  ALU flags for the instruction in EX (Carry = no-borrow of A-B)
ImmSrc_D_o  out  3  immediate select in ID (combinational)
Illegal_D_o  out  1  ID instruction unsupported (combinational)
ALUCtrl_E_o  out  ALU_CTRL_WIDTH  ALU op in EX
ALUSrc_E_o  out  1  1 = immediate operand B
Load_E_o  out  1  EX holds a load (to hazard unit)
PCSrc_E_o  out  1  redirect PC this cycle (combinational from EX regs + flags)
Jalr_E_o  out  1  target = ALU result, else PC+imm
FlushD_o  out  1  squash IF/ID (equal to PCSrc_E_o)
MemWrite_M_o  out  1  store in MEM
MemType_M_o  out  2  00 word, 01 byte, 10 half
MemSign_M_o  out  1  1 = zero-extend load (funct3[2])
RegWrite_M_o, RegWrite_W_o  out  1 each  register write in MEM / WB
ResultSrc_W_o  out  2  00 ALU, 01 memory, 10 PC+4

Behaviour:
- Reset: every registered field is cleared in all three stages, so all outputs are 0 (bubble). Reset takes effect immediately on assertion, including mid-pipeline.
- ALU control encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 srl, 1000 sll, 1001 sra, 1010 pass-B (lui).
  - With M_EXT=1: 1011 mul, 1100 mulh, 1101 mulhsu, 1110 mulhu.
- ImmSrc encoding: 000 I, 001 S, 010 B, 011 U, 100 J.
- Decode rules:
  - sub only when op=51 and funct7[5]=1.
  - sra/srai on funct7[5] for both op=19 and op=51.
  - lui uses pass-B; auipc uses add.
  - Branches use sub and ALUSrc=0.
  - jalr uses add with ALUSrc=1.
- Illegal instructions assert Illegal_D_o and decode to an all-zero bubble:
  - unknown opcode;
  - load funct3 of 011/110/111;
  - store funct3 > 010;
  - branch funct3 of 010/011;
  - R-type funct7 not in {0000000, 0100000 (add/sub, srl/sra only), 0000001 (M_EXT=1, funct3<100)}.
- Pipeline: decoded fields enter EX one edge after ID, MEM after two, WB after three. The WB-only fields travel through MEM.
- Branch resolution (EX, combinational):
  - beq Z; bne !Z.
  - blt N^V; bge !(N^V).
  - bltu !C; bgeu C.
  - jal/jalr always taken.
  - PCSrc_E_o = Branch_E & cond, or Jump_E.
- ID/EX capture priority, highest first:
  - rst_i;
  - PCSrc_E_o=1, which loads a bubble (the wrong-path ID instruction is squashed);
  - BubbleE_i=1, which loads a bubble;
  - StallD_i=1 alone, which holds the ID/EX contents;
  - otherwise the ID decode is loaded.
- EX/MEM and MEM/WB always advance; stall never blocks them.
- A bubble contains only a valid NOP: RegWrite, MemWrite, Branch and Jump are 0.

Test Plan:
- Reset mid-stream with a lw in MEM: assert rst_i async → all outputs 0 before the next edge; after release, the first instruction appears in EX one edge later.
- Instr_i=0x002081B3 (add) then 0x402081B3 (sub): ALUCtrl_E_o=0000 then 0001, ALUSrc_E_o=0; 3 edges later RegWrite_W_o=1, ResultSrc_W_o=00.
- 0x00000063 (beq) in EX with Zero_i=1 → PCSrc_E_o=1, FlushD_o=1; next cycle EX fields all 0. Repeat with Zero_i=0 → PCSrc_E_o=0.
- 0x0020C063 (blt): N=1,V=0 → taken; N=1,V=1 → not taken. bltu/bgeu swept with Carry_i 0/1 for the inverse results.
- 0x0000A183 (lw) followed by BubbleE_i=1: Load_E_o=1 for the lw; next cycle EX is a bubble while MEM shows MemType_M_o=00, MemSign_M_o=0; the WB cycle after that shows ResultSrc_W_o=01.
- 0x022081B3 (mul): M_EXT=1 → ALUCtrl_E_o=1011, Illegal_D_o=0; M_EXT=0 → Illegal_D_o=1 and EX fields 0.
